ext_param_flash_reader: RTL and testbench
=========================================

EXT_PARAM_FLASH_READER -- requirements
Module: ext_param_flash_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, parameter word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_W, default 15, parameter word address width.
REQ-003 SHALL have parameter SCLK_DIV, default 2, number of clk cycles per SCLK half-period (>=1).
REQ-004 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port read_pulse, input, 1, one-cycle request from the master FSM.
REQ-007 SHALL have port addr, input, ADDR_W, word address, sampled when read_pulse is high.
REQ-008 SHALL have port data, output, DATA_W, signed parameter word returned to the master.
REQ-009 SHALL have port data_valid, output, 1, one-cycle strobe qualifying data.
REQ-010 SHALL have port busy, output, 1, high while a flash transaction or the CS-high gap is in progress.
REQ-011 SHALL have ports spi_sclk (output, 1), spi_cs_n (output, 1), spi_mosi (output, 1) and spi_miso (input, 1), SPI mode 0 flash interface.

Function
REQ-012 SHALL implement the states IDLE, SHIFT and GAP.
REQ-013 In IDLE with read_pulse=1, SHALL latch addr, drive spi_cs_n=0 on the next cycle and enter SHIFT.
REQ-014 In SHIFT, SHALL shift out 32+DATA_W bit periods MSB-first: command 0x03 (8b), then byte address = addr*(DATA_W/8) zero-extended to 24b, then DATA_W don't-care bits with spi_mosi=0.
REQ-015 Each bit period SHALL last 2*SCLK_DIV clk cycles, with spi_sclk low for the first SCLK_DIV cycles and high for the rest.
REQ-016 spi_mosi SHALL change only while spi_sclk is low.
REQ-017 spi_miso SHALL be sampled on the clk edge that raises spi_sclk, during the last DATA_W bit periods only; the first received bit is the MSB.
REQ-018 At the end of the last bit period, the block SHALL in the same cycle:
  - drive spi_cs_n=1 and spi_sclk=0;
  - update data with the assembled word;
  - pulse data_valid for exactly one cycle;
  - enter GAP.
REQ-019 The latency from read_pulse sampled in IDLE to data_valid SHALL be exactly 1+2*SCLK_DIV*(32+DATA_W) cycles (193 at defaults).
REQ-020 data SHALL hold its value until the next data_valid.
REQ-021 data_valid SHALL never be high on two consecutive cycles.
REQ-022 GAP SHALL last 2*SCLK_DIV cycles with spi_cs_n=1; at its end the block SHALL enter SHIFT if a request is pending, otherwise IDLE.
REQ-023 read_pulse arriving in SHIFT or GAP SHALL be stored in a one-deep pending register (address included); a later pulse SHALL overwrite the stored request (last wins).
REQ-024 Pending requests SHALL NOT be served out of order or duplicated.
REQ-025 read_pulse on the same cycle GAP ends SHALL be served as the next transaction, overriding any older pending request.
REQ-026 busy SHALL be high in SHIFT and GAP, and in IDLE whenever a request is pending.
REQ-027 The bit counter SHALL be wide enough for 32+DATA_W without wrap.
REQ-028 The byte-address multiply SHALL be truncated to 24b; bits above bit 23 are discarded.

Reset
REQ-029 While rst_n=0, the block SHALL set state=IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, data=0, data_valid=0, busy=0, and clear the pending request.
REQ-030 Reset during SHIFT SHALL abort the transaction, with spi_cs_n=1 on the first reset edge and no data_valid afterwards for the aborted request.
REQ-031 read_pulse SHALL be ignored while rst_n=0.

Verification
REQ-032 Bench SHALL cover a single read: defaults, addr=0x0005, flash model returns 0xBEEF at byte 0x00000A.
  - MOSI SHALL show 0x03, 0x00000A.
  - data_valid SHALL occur 193 cycles after read_pulse with data=0xBEEF (signed -16657).
  - spi_cs_n SHALL be high on the data_valid cycle.
REQ-033 Bench SHALL cover back-to-back requests: pulses at addr 1 and 2 with the second pulse 10 cycles after the first.
  - Two data_valid strobes in order, words at bytes 0x2 then 0x4.
  - Second strobe exactly 193+4 cycles after the first.
REQ-034 Bench SHALL cover overwrite: pulses at addr 3, then 4 and 5 during SHIFT.
  - Only words for 3 and 5 are returned, exactly two data_valid strobes.
REQ-035 Bench SHALL cover reset mid-transaction: rst_n=0 for 1 cycle at cycle 50 of a read.
  - spi_cs_n=1 on the next cycle.
  - No data_valid.
  - busy=0.
  - A subsequent read returns correct data.
REQ-036 Bench SHALL cover SCLK_DIV=1 with DATA_W=8, addr=0x7FFF.
  - Byte address 0x007FFF.
  - Latency 81 cycles.
  - sclk period 2 cycles.
  - MISO sampled only on rising sclk edges.

Source files
------------

// File: rtl/ext_param_flash_reader.sv
// Reads one parameter word from a SPI (mode 0) serial flash with the 0x03 READ command.
// Requests arriving mid-transaction are held in a one-deep, last-wins pending slot.
module ext_param_flash_reader #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 15,
  parameter int SCLK_DIV = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     read_pulse,
  input  logic [ADDR_W-1:0]        addr,
  output logic signed [DATA_W-1:0] data,
  output logic                     data_valid,
  output logic                     busy,
  output logic                     spi_sclk,
  output logic                     spi_cs_n,
  output logic                     spi_mosi,
  input  logic                     spi_miso
);

  localparam int NBITS = 32 + DATA_W;
  localparam int BIT_W = $clog2(NBITS + 1);
  localparam int DIV_W = $clog2(2 * SCLK_DIV + 1);
  localparam int BYTES = DATA_W / 8;

  localparam logic [DIV_W-1:0] RISE_AT    = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] PERIOD_END = DIV_W'(2 * SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_END    = DIV_W'(2 * SCLK_DIV);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(NBITS - 1);
  localparam logic [BIT_W-1:0] FIRST_RX   = BIT_W'(32);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  state_e              state_q, state_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [31:0]         tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;

  logic                start;
  logic [ADDR_W-1:0]   start_addr;
  logic [23:0]         byte_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Truncating both operands to 24b first yields the low 24b of the full product.
  assign byte_addr = 24'(start_addr) * 24'(BYTES);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    start       = 1'b0;
    start_addr  = addr;

    case (state_q)
      IDLE: begin
        if (read_pulse) begin
          start = 1'b1;
        end else if (pend_q) begin
          start      = 1'b1;
          start_addr = pend_addr_q;
        end
      end

      SHIFT: begin
        if (read_pulse) begin
          pend_d      = 1'b1;
          pend_addr_d = addr;
        end
        if (div_cnt_q == RISE_AT) begin
          sclk_d    = 1'b1;
          div_cnt_d = div_cnt_q + DIV_W'(1);
          if (bit_cnt_q >= FIRST_RX) begin
            rx_d = {rx_q[DATA_W-2:0], spi_miso};
          end
        end else if (div_cnt_q == PERIOD_END) begin
          sclk_d    = 1'b0;
          div_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            cs_n_d  = 1'b1;
            data_d  = rx_q;
            valid_d = 1'b1;
            state_d = GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_d      = {tx_q[30:0], 1'b0};
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      GAP: begin
        // The strobe cycle closes the last bit period; the CS-high gap is the 2*SCLK_DIV cycles after it.
        if (div_cnt_q == GAP_END) begin
          if (read_pulse) begin
            start = 1'b1;
          end else if (pend_q) begin
            start      = 1'b1;
            start_addr = pend_addr_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
          if (read_pulse) begin
            pend_d      = 1'b1;
            pend_addr_d = addr;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d   = SHIFT;
      cs_n_d    = 1'b0;
      sclk_d    = 1'b0;
      div_cnt_d = '0;
      bit_cnt_d = '0;
      rx_d      = '0;
      tx_d      = {8'h03, byte_addr};
      pend_d    = 1'b0;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != IDLE) || pend_q;
  assign spi_sclk   = sclk_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_mosi   = tx_q[31];

endmodule

// File: tb/tb_ext_param_flash_reader.sv
// Bench for ext_param_flash_reader: lane 0 uses default parameters, lane 1 uses DATA_W=8, SCLK_DIV=1.
// A behavioural mode-0 flash drives MISO; a scoreboard queue holds the expected returned words.
module tb_ext_param_flash_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic readPulse0, readPulse1;
  logic [14:0] addr0, addr1;
  logic signed [15:0] data0;
  logic signed [7:0] data1;
  logic dv0, dv1, busy0, busy1, sclk0, sclk1, csn0, csn1, mosi0, mosi1;
  logic misoL[2];

  ext_param_flash_reader dut0 (
    .clk(clk), .rst_n(rst_n), .read_pulse(readPulse0), .addr(addr0),
    .data(data0), .data_valid(dv0), .busy(busy0),
    .spi_sclk(sclk0), .spi_cs_n(csn0), .spi_mosi(mosi0), .spi_miso(misoL[0])
  );

  ext_param_flash_reader #(.DATA_W(8), .ADDR_W(15), .SCLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .read_pulse(readPulse1), .addr(addr1),
    .data(data1), .data_valid(dv1), .busy(busy1),
    .spi_sclk(sclk1), .spi_cs_n(csn1), .spi_mosi(mosi1), .spi_miso(misoL[1])
  );

  logic sclkL[2], csnL[2], mosiL[2], dvL[2], busyL[2];
  logic [31:0] dataL[2];
  assign sclkL[0] = sclk0;  assign sclkL[1] = sclk1;
  assign csnL[0]  = csn0;   assign csnL[1]  = csn1;
  assign mosiL[0] = mosi0;  assign mosiL[1] = mosi1;
  assign dvL[0]   = dv0;    assign dvL[1]   = dv1;
  assign busyL[0] = busy0;  assign busyL[1] = busy1;
  assign dataL[0] = {16'h0000, data0};
  assign dataL[1] = {24'h000000, data1};

  typedef struct {
    int          lane;
    logic [23:0] byteAddr;
    logic [15:0] word;
    int          cycle;
  } expEntry_t;

  expEntry_t sbQ[$];
  expEntry_t popped;
  int vectorCount = 0;
  int missCount = 0;
  int cycleCount = 0;
  int lastPulse = 0;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycleCount);
    end
  endtask

  function automatic logic [7:0] memByte(input logic [23:0] b);
    if (b == 24'h00000A) return 8'hBE;
    if (b == 24'h00000B) return 8'hEF;
    return (b[7:0] * 8'h1D) ^ b[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [15:0] flashWord(input int lane, input logic [23:0] b);
    if (lane == 0) return {memByte(b), memByte(b + 24'd1)};
    return {8'h00, memByte(b)};
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle request from the current cycle and records its expected result.
  task automatic applyStimulus(input int lane, input logic [14:0] a, input bit replaceLast, input int expCycle);
    expEntry_t e;
    e.lane     = lane;
    e.byteAddr = (lane == 0) ? 24'(a) * 24'd2 : 24'(a);
    e.word     = flashWord(lane, e.byteAddr);
    e.cycle    = (expCycle == 0) ? cycleCount + ((lane == 0) ? 193 : 81) : expCycle;
    if (replaceLast && sbQ.size() > 0) void'(sbQ.pop_back());
    sbQ.push_back(e);
    lastPulse = cycleCount;
    if (lane == 0) begin
      readPulse0 = 1'b1;
      addr0 = a;
    end else begin
      readPulse1 = 1'b1;
      addr1 = a;
    end
    @(posedge clk);
    #1;
    readPulse0 = 1'b0;
    readPulse1 = 1'b0;
  endtask

  task automatic drain(input int maxCycles);
    int k = 0;
    while (sbQ.size() != 0 && k < maxCycles) begin
      @(posedge clk);
      k++;
    end
    #1;
    checkOutput("drain", sbQ.size(), 0);
  endtask

  // Flash model and output monitor, sampling on the falling clk edge.
  int rxCnt[2] = '{0, 0};
  int lastRise[2] = '{0, 0};
  logic [31:0] shiftIn[2];
  logic [15:0] outWord[2];
  logic prevSclk[2] = '{1'b0, 1'b0};
  logic prevMosi[2] = '{1'b0, 1'b0};
  logic prevDv[2] = '{1'b0, 1'b0};
  logic [31:0] prevData[2] = '{32'h0, 32'h0};
  logic prevRst = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int wid;
      int div;
      wid = (i == 0) ? 16 : 8;
      div = (i == 0) ? 2 : 1;
      if (dvL[i]) begin
        checkOutput("dvDouble", prevDv[i], 0);
        checkOutput("csnAtValid", csnL[i], 1);
        checkOutput("sclkAtValid", sclkL[i], 0);
        checkOutput("bitPeriods", rxCnt[i], 32 + wid);
        checkOutput("busyInGap", busyL[i], 1);
        if (sbQ.size() == 0) begin
          checkOutput("dvUnexpected", dvL[i], 0);
        end else begin
          popped = sbQ.pop_front();
          checkOutput("lane", i, popped.lane);
          checkOutput("data", dataL[i], {16'h0000, popped.word});
          checkOutput("latency", cycleCount, popped.cycle);
        end
      end else if (prevRst && rst_n && dataL[i] !== prevData[i]) begin
        checkOutput("dataHold", dataL[i], prevData[i]);
      end

      if (csnL[i]) begin
        rxCnt[i] = 0;
        misoL[i] = 1'($urandom);
      end else begin
        if (mosiL[i] !== prevMosi[i]) checkOutput("mosiEdge", sclkL[i], 0);
        if (sclkL[i] && !prevSclk[i]) begin
          if (rxCnt[i] > 0) checkOutput("sclkPeriod", cycleCount - lastRise[i], 2 * div);
          lastRise[i] = cycleCount;
          checkOutput("busyInShift", busyL[i], 1);
          if (rxCnt[i] < 32) begin
            shiftIn[i] = {shiftIn[i][30:0], mosiL[i]};
            misoL[i] = 1'($urandom);
          end else begin
            checkOutput("mosiIdle", mosiL[i], 0);
            misoL[i] = ~misoL[i];
          end
          rxCnt[i]++;
          if (rxCnt[i] == 32) begin
            checkOutput("cmd", shiftIn[i][31:24], 8'h03);
            if (sbQ.size() > 0) checkOutput("byteAddr", shiftIn[i][23:0], sbQ[0].byteAddr);
            else checkOutput("addrNoRequest", sbQ.size(), 1);
            outWord[i] = flashWord(i, shiftIn[i][23:0]);
          end
        end else if (!sclkL[i] && prevSclk[i] && rxCnt[i] >= 32 && rxCnt[i] < 32 + wid) begin
          misoL[i] = outWord[i][wid - 1 - (rxCnt[i] - 32)];
        end
      end
      prevSclk[i] = sclkL[i];
      prevMosi[i] = mosiL[i];
      prevDv[i]   = dvL[i];
      prevData[i] = dataL[i];
    end
    prevRst = rst_n;
  end

  initial begin
    int c;
    rst_n = 1'b0;
    readPulse0 = 1'b0;
    readPulse1 = 1'b0;
    addr0 = '0;
    addr1 = '0;
    misoL[0] = 1'b0;
    misoL[1] = 1'b0;
    waitCycles(3);
    for (int i = 0; i < 2; i++) begin
      checkOutput("resetCsn", csnL[i], 1);
      checkOutput("resetSclk", sclkL[i], 0);
      checkOutput("resetMosi", mosiL[i], 0);
      checkOutput("resetValid", dvL[i], 0);
      checkOutput("resetBusy", busyL[i], 0);
      checkOutput("resetData", dataL[i], 0);
    end
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] single read at addr 0x0005");
    applyStimulus(0, 15'h0005, 1'b0, 0);
    drain(300);
    checkOutput("beefWord", dataL[0], 32'h0000BEEF);
    checkOutput("beefSigned", int'(data0), -16657);
    waitCycles(10);

    $display("[TB] back-to-back reads at addr 1 and 2");
    applyStimulus(0, 15'h0001, 1'b0, 0);
    c = lastPulse;
    waitCycles(9);
    applyStimulus(0, 15'h0002, 1'b0, c + 193 + 197);
    drain(600);
    waitCycles(10);

    $display("[TB] overwrite: addr 3, then 4 and 5 during SHIFT");
    applyStimulus(0, 15'h0003, 1'b0, 0);
    c = lastPulse;
    waitCycles(19);
    applyStimulus(0, 15'h0004, 1'b0, c + 193 + 197);
    waitCycles(19);
    applyStimulus(0, 15'h0005, 1'b1, c + 193 + 197);
    drain(600);
    waitCycles(10);
    checkOutput("idleBusy", busy0, 0);

    $display("[TB] reset in the middle of a read");
    applyStimulus(0, 15'h0042, 1'b0, 0);
    waitCycles(49);
    rst_n = 1'b0;
    readPulse0 = 1'b1;
    addr0 = 15'h0077;
    sbQ.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    readPulse0 = 1'b0;
    checkOutput("abortCsn", csn0, 1);
    checkOutput("abortBusy", busy0, 0);
    checkOutput("abortValid", dv0, 0);
    checkOutput("abortData", dataL[0], 0);
    waitCycles(300);
    checkOutput("abortStillIdle", busy0, 0);
    applyStimulus(0, 15'h0123, 1'b0, 0);
    drain(400);
    waitCycles(10);

    $display("[TB] DATA_W=8, SCLK_DIV=1 lane");
    applyStimulus(1, 15'h7FFF, 1'b0, 0);
    drain(200);
    waitCycles(5);
    applyStimulus(1, 15'h0010, 1'b0, 0);
    drain(200);
    waitCycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
